data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Byte-addressed, byte-lane-enabled data memory with an integrated load/store formatter, the next-generation data memory for the pipelined RISC-V core. It accepts one load or store request per cycle, applies RV32I size and sign rules (LB/LH/LW/LBU/LHU, SB/SH/SW), and returns load data through a registered read port one cycle after the request. Misaligned accesses, illegal size codes and out-of-range addresses are rejected with an error pulse. Such accesses never corrupt memory.

## Interface
- P_ADDR_WIDTH, 13: byte-address width. Depth is 2**(P_ADDR_WIDTH-2) words.
- P_DATA_WIDTH, 32: word width. Fixed at 32; any other value is an elaboration error.
- P_MEM_BYTES, 2**P_ADDR_WIDTH: populated size in bytes. Addresses greater than or equal to this value are out of range.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_req  in  1  request valid this cycle.
- i_we  in  1  1 = store, 0 = load. Only meaningful when i_req=1.
- i_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  P_ADDR_WIDTH  byte address.
- i_wdata  in  32  store data, right-aligned. Only the low byte or halfword is used for B and H.
- o_rdata  out  32  formatted load data (sign- or zero-extended).
- o_rvalid  out  1  one-cycle pulse: load data valid.
- o_err  out  1  one-cycle pulse: previous request faulted.

## Operation
- The block is always ready; there is no backpressure. Every cycle with i_req=1 is an accepted request.
- Fault checks on the request:
  - H/HU with i_addr[0]≠0 faults.
  - W with i_addr[1:0]≠0 faults.
  - funct3 of 011, 110 or 111 faults. 100 and 101 with i_we=1 also fault.
  - Any access with i_addr ≥ P_MEM_BYTES faults.
- A faulting request writes nothing and produces o_err=1, o_rvalid=0 in the next cycle.
- Store byte enables:
  - SB sets lane i_addr[1:0] from wdata[7:0].
  - SH sets lanes {i_addr[1],0} and {i_addr[1],1} from wdata[15:0].
  - SW sets all four lanes.
  - All other lanes of the word are unchanged.
- Load formatting: the word is read and the lane is selected by the address registered in the request cycle.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- A valid store produces no response pulse.
- Memory contents are not reset and are undefined until written. $readmemh preload is optional via simulation-only code.
- Response state machine with two states:
  - IDLE, then RESP on an accepted load or any fault.
  - RESP, then RESP if a new load or fault is accepted this cycle, otherwise IDLE.
  - o_rvalid/o_err are asserted only in RESP.

## Timing
- Store accepted in cycle N is committed at the rising edge closing cycle N.
- Load accepted in cycle N gives o_rvalid=1 and o_rdata valid in cycle N+1. Latency is 1 cycle, and back-to-back loads give a pulse every cycle.
- Store in N followed by a load to the same word in N+1 returns the newly written data (write-first across cycles).
- o_rdata holds its last load value while o_rvalid=0. It is not updated by stores or faults.
- Reset values: o_rdata=0, o_rvalid=0, o_err=0, FSM in IDLE.
- Reset has priority over requests. A store presented in a cycle with i_rst=1 is not committed, and a load is dropped with no response.
- Reset asserted in the cycle in which a response is due forces o_rvalid=0 and o_err=0 on the following edge.
- Address wrap is forbidden; out-of-range addresses fault rather than alias.

## Structure
- Package mem_pkg holds:
  - the mem_size_e enum for the funct3 codes;
  - localparams for byte-lane count (4) and word-offset bits (2);
  - the function computing the 4-bit byte-enable from size and offset.
- Sub-module dmem_byte_ram is a word array with a 4-bit byte-write-enable and a registered read port. data_memory_lsu contains the fault check, byte-enable and wdata replication, the response FSM and load formatting.

## Test plan
- Reset, then SW 0xDEADBEEF to addr 0x010, then LW addr 0x010 → o_rvalid exactly at N+1, o_rdata=0xDEADBEEF, o_err=0.
- SB 0x7F to 0x011, then LW 0x010 → 0xDEAD7FEF. LB 0x013 → 0xFFFFFFDE. LBU 0x013 → 0x000000DE.
- SH 0x8001 to 0x012, then LH 0x012 → 0xFFFF8001. LHU 0x012 → 0x00008001.
- LW 0x012, SH to 0x011, and funct3=011 → o_err pulse each, o_rvalid=0, and a subsequent LW 0x010 is unchanged. An access at P_MEM_BYTES → o_err.
- Back-to-back LW 0x000, 0x004, 0x008 on consecutive cycles → three consecutive o_rvalid pulses with the correct data in order.
- SW to 0x020 with i_rst=1 in the same cycle → after reset, LW 0x020 returns the prior contents. A load with reset asserted on its response cycle → no o_rvalid.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types, lane constants and byte-enable helper for the LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_e;

    localparam int c_NUM_LANES   = 4;
    localparam int c_OFFSET_BITS = 2;

    function automatic logic [c_NUM_LANES-1:0] byte_enable(
        input logic [2:0]               funct3,
        input logic [c_OFFSET_BITS-1:0] offset
    );
        logic [c_NUM_LANES-1:0] be;
        be = '0;
        case (funct3)
            MEM_B:   be = 4'b0001 << offset;
            MEM_H:   be = offset[1] ? 4'b1100 : 4'b0011;
            MEM_W:   be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_ram.sv
// ============================================================================
// Module : dmem_byte_ram
// Brief  : Word array with per-byte write enables and a registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_byte_ram #(
    parameter int WORD_ADDR_BITS = 11
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [WORD_ADDR_BITS-1:0] i_addr,
    input  logic [3:0]                i_be,
    input  logic [31:0]               i_wdata,
    input  logic                      i_re,
    output logic [31:0]               o_rdata
);

    logic [31:0] r_mem_q [0:(2**WORD_ADDR_BITS)-1];
    logic [31:0] r_rdata_q;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        always_ff @(posedge i_clk) begin
            if (i_be[g]) begin
                r_mem_q[i_addr][8*g +: 8] <= i_wdata[8*g +: 8];
            end
        end
    end

    // Read register only loads on an accepted load so the formatted output holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata_q <= '0;
        end else if (i_re) begin
            r_rdata_q <= r_mem_q[i_addr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_lsu.sv
// ============================================================================
// Module : data_memory_lsu
// Brief  : RV32I load/store unit with fault checking over a byte-lane RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_lsu
    import mem_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 13,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_MEM_BYTES  = 2**P_ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [2:0]              i_funct3,
    input  logic [P_ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata,
    output logic                    o_rvalid,
    output logic                    o_err
);

    if (P_DATA_WIDTH != 32) begin : g_bad_width
        $error("data_memory_lsu: P_DATA_WIDTH must be 32");
    end

    logic                     w_in_range;
    logic                     w_bad_code;
    logic                     w_fault;
    logic                     w_load_ok;
    logic                     w_store_ok;
    logic [c_NUM_LANES-1:0]   w_be;
    logic [31:0]              w_wdata_rep;
    logic [31:0]              w_ram_rdata;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;

    resp_state_e              r_state_q, w_state_d;
    logic                     r_err_q, w_err_d;
    logic [2:0]               r_funct3_q;
    logic [c_OFFSET_BITS-1:0] r_offset_q;

    if (P_MEM_BYTES >= 2**P_ADDR_WIDTH) begin : g_full_range
        assign w_in_range = 1'b1;
    end else begin : g_partial_range
        assign w_in_range = (32'(i_addr) < 32'(P_MEM_BYTES));
    end

    always_comb begin
        w_bad_code = 1'b1;
        case (i_funct3)
            MEM_B:   w_bad_code = 1'b0;
            MEM_H:   w_bad_code = i_addr[0];
            MEM_W:   w_bad_code = |i_addr[1:0];
            MEM_BU:  w_bad_code = i_we;
            MEM_HU:  w_bad_code = i_we | i_addr[0];
            default: w_bad_code = 1'b1;
        endcase
    end

    assign w_fault    = w_bad_code | ~w_in_range;
    assign w_load_ok  = i_req & ~i_we & ~w_fault & ~i_rst;
    assign w_store_ok = i_req &  i_we & ~w_fault & ~i_rst;
    assign w_be       = w_store_ok ? byte_enable(i_funct3, i_addr[1:0]) : '0;

    always_comb begin
        w_wdata_rep = i_wdata;
        case (i_funct3)
            MEM_B:   w_wdata_rep = {4{i_wdata[7:0]}};
            MEM_H:   w_wdata_rep = {2{i_wdata[15:0]}};
            default: w_wdata_rep = i_wdata;
        endcase
    end

    dmem_byte_ram #(
        .WORD_ADDR_BITS(P_ADDR_WIDTH - c_OFFSET_BITS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_addr  (i_addr[P_ADDR_WIDTH-1:c_OFFSET_BITS]),
        .i_be    (w_be),
        .i_wdata (w_wdata_rep),
        .i_re    (w_load_ok),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_d = ST_IDLE;
        w_err_d   = 1'b0;
        if (i_req && (w_fault || !i_we)) begin
            w_state_d = ST_RESP;
            w_err_d   = w_fault;
        end
    end

    // Lane/format select is captured only on accepted loads so o_rdata holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= ST_IDLE;
            r_err_q    <= 1'b0;
            r_funct3_q <= MEM_W;
            r_offset_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_err_q   <= w_err_d;
            if (w_load_ok) begin
                r_funct3_q <= i_funct3;
                r_offset_q <= i_addr[1:0];
            end
        end
    end

    assign o_rvalid = (r_state_q == ST_RESP) & ~r_err_q;
    assign o_err    = (r_state_q == ST_RESP) &  r_err_q;

    always_comb begin
        w_byte  = w_ram_rdata[{r_offset_q, 3'b000} +: 8];
        w_half  = r_offset_q[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
        o_rdata = w_ram_rdata;
        case (r_funct3_q)
            MEM_B:   o_rdata = {{24{w_byte[7]}}, w_byte};
            MEM_H:   o_rdata = {{16{w_half[15]}}, w_half};
            MEM_BU:  o_rdata = {24'h0, w_byte};
            MEM_HU:  o_rdata = {16'h0, w_half};
            default: o_rdata = w_ram_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
// ============================================================================
// Module : tb_data_memory_lsu
// Brief  : Self-checking bench for data_memory_lsu with a byte-array model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_memory_lsu;

    localparam int AW   = 13;
    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    data_memory_lsu #(
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (32),
        .P_MEM_BYTES  (MEMB)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_we     (we),
        .i_funct3 (f3),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_rvalid (rvalid),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    logic [7:0]  model [0:MEMB-1];
    logic [31:0] exp_rdata;
    logic        exp_rv;
    logic        exp_err;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        rv;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic w, logic [2:0] f, logic [12:0] a, logic [31:0] d,
                                logic e, logic v, logic [31:0] r);
        vec_t t;
        t.we = w; t.f3 = f; t.addr = a; t.wdata = d;
        t.err = e; t.rv = v; t.rdata = r;
        return t;
    endfunction

    function automatic int access_bytes(logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_fault(logic w, logic [2:0] f, logic [12:0] a);
        int n;
        n = access_bytes(f);
        if (n == 0) return 1'b1;
        if (w && f >= 3'd4) return 1'b1;
        if ((int'(a) % n) != 0) return 1'b1;
        return (int'(a) + n) > MEMB;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f, logic [12:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < access_bytes(f); i++) v[8*i +: 8] = model[int'(a) + i];
        if (f == 3'd0) v = 32'($signed(v[7:0]));
        if (f == 3'd1) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic q, input logic w, input logic [2:0] f,
                         input logic [12:0] a, input logic [31:0] d);
        rst = r; req = q; we = w; f3 = f; addr = a; wdata = d;
        @(posedge clk);
        exp_rv  = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            exp_rdata = '0;
        end else if (q && model_fault(w, f, a)) begin
            exp_err = 1'b1;
        end else if (q && w) begin
            for (int i = 0; i < access_bytes(f); i++) model[int'(a) + i] = d[8*i +: 8];
        end else if (q) begin
            exp_rdata = model_load(f, a);
            exp_rv    = 1'b1;
        end
        #1;
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        check("err",    32'(err),    32'(exp_err));
        check("rdata",  rdata,       exp_rdata);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = '0; wdata = '0;
        exp_rdata = '0; exp_rv = 1'b0; exp_err = 1'b0;

        cycle(1, 0, 0, 3'd0, 13'h0, 32'h0);
        cycle(1, 0, 0, 3'd0, 13'h0, 32'h0);

        tbl.push_back(mk(1, 3'd2, 13'h010, 32'hDEADBEEF, 0, 0, 32'h00000000));
        tbl.push_back(mk(0, 3'd2, 13'h010, 32'h0,        0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 3'd0, 13'h011, 32'h0000007F, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 3'd2, 13'h010, 32'h0,        0, 1, 32'hDEAD7FEF));
        tbl.push_back(mk(0, 3'd0, 13'h013, 32'h0,        0, 1, 32'hFFFFFFDE));
        tbl.push_back(mk(0, 3'd4, 13'h013, 32'h0,        0, 1, 32'h000000DE));
        tbl.push_back(mk(1, 3'd1, 13'h012, 32'h00008001, 0, 0, 32'h000000DE));
        tbl.push_back(mk(0, 3'd1, 13'h012, 32'h0,        0, 1, 32'hFFFF8001));
        tbl.push_back(mk(0, 3'd5, 13'h012, 32'h0,        0, 1, 32'h00008001));
        tbl.push_back(mk(0, 3'd2, 13'h012, 32'h0,        1, 0, 32'h00008001));
        tbl.push_back(mk(1, 3'd1, 13'h011, 32'h0000BEEF, 1, 0, 32'h00008001));
        tbl.push_back(mk(0, 3'd3, 13'h010, 32'h0,        1, 0, 32'h00008001));
        tbl.push_back(mk(0, 3'd2, 13'h010, 32'h0,        0, 1, 32'h80017FEF));
        tbl.push_back(mk(0, 3'd2, 13'h1000, 32'h0,       1, 0, 32'h80017FEF));
        tbl.push_back(mk(1, 3'd2, 13'h000, 32'h11111111, 0, 0, 32'h80017FEF));
        tbl.push_back(mk(1, 3'd2, 13'h004, 32'h22222222, 0, 0, 32'h80017FEF));
        tbl.push_back(mk(1, 3'd2, 13'h008, 32'h33333333, 0, 0, 32'h80017FEF));
        tbl.push_back(mk(0, 3'd2, 13'h000, 32'h0,        0, 1, 32'h11111111));
        tbl.push_back(mk(0, 3'd2, 13'h004, 32'h0,        0, 1, 32'h22222222));
        tbl.push_back(mk(0, 3'd2, 13'h008, 32'h0,        0, 1, 32'h33333333));
        tbl.push_back(mk(1, 3'd2, 13'h020, 32'hAAAA5555, 0, 0, 32'h33333333));
        tbl.push_back(mk(1, 3'd4, 13'h020, 32'h000000FF, 1, 0, 32'h33333333));
        tbl.push_back(mk(0, 3'd2, 13'h020, 32'h0,        0, 1, 32'hAAAA5555));

        foreach (tbl[i]) begin
            cycle(0, 1, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            check($sformatf("vec%0d_err", i),    32'(err),    32'(tbl[i].err));
            check($sformatf("vec%0d_rdata", i),  rdata,       tbl[i].rdata);
        end

        // Store during reset must not commit.
        cycle(1, 1, 1, 3'd2, 13'h020, 32'h12345678);
        cycle(0, 1, 0, 3'd2, 13'h020, 32'h0);
        check("rst_store_dropped", rdata, 32'hAAAA5555);

        // Reset in the response cycle clears the pulse on the next edge.
        cycle(0, 1, 0, 3'd2, 13'h010, 32'h0);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        cycle(1, 0, 0, 3'd0, 13'h0, 32'h0);
        check("rst_resp_rvalid", 32'(rvalid), 32'd0);

        // Load presented with reset yields no response.
        cycle(1, 1, 0, 3'd2, 13'h010, 32'h0);
        cycle(0, 0, 0, 3'd0, 13'h0, 32'h0);
        check("rst_load_dropped", 32'(rvalid), 32'd0);

        for (int w = 0; w < 16; w++) cycle(0, 1, 1, 3'd2, 13'(w * 4), $urandom);

        for (int n = 0; n < 500; n++) begin
            logic [12:0] a;
            a = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(MEMB, 8191))
                                            : 13'($urandom_range(0, 63));
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
